// File: rtl/scene_pkg.sv
// scene_pkg: scene codes, sequencer FSM states and fade constants shared by scene_sequencer.
package scene_pkg;
   typedef enum logic [1:0] {SC_TITLE, SC_INTRO, SC_PLAY, SC_OVER} scene_e;
   typedef enum logic [2:0] {HOLD_TITLE, HOLD_INTRO, HOLD_PLAY, HOLD_OVER, FADE_OUT, FADE_IN} state_e;
   localparam logic [3:0] FADE_MAX = 4'd8;
   // Hold states are enumerated in scene-code order, so the mapping is a zero-extension.
   function automatic state_e hold_of(input scene_e s);
      return state_e'({1'b0, s});
   endfunction
endpackage

// File: rtl/fade_scaler.sv
// fade_scaler: registered scene mux, per-channel fade scaling and blank gating.
// With SCENE_FADE_EN undefined the fade_level port and the multipliers are absent.
module fade_scaler
   import scene_pkg::*;
(
   input  logic        vga_clk,
   input  logic        reset,
   input  logic [11:0] title_rgb,
   input  logic [11:0] intro_rgb,
   input  logic [11:0] play_rgb,
   input  logic [11:0] over_rgb,
   input  logic [1:0]  scene,
`ifdef SCENE_FADE_EN
   input  logic [3:0]  fade_level,
`endif
   input  logic        blank,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue
);
   logic [11:0] px, scaled;
   assign px = scene == SC_TITLE ? title_rgb :
               scene == SC_INTRO ? intro_rgb :
               scene == SC_PLAY  ? play_rgb  : over_rgb;
`ifdef SCENE_FADE_EN
   // Level 8 is full scale, so bits [6:3] of the product give c at level 8.
   function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] f);
      return 4'((8'(c) * 8'(f)) >> 3);
   endfunction
   assign scaled = {scale(px[11:8], fade_level), scale(px[7:4], fade_level), scale(px[3:0], fade_level)};
`else
   assign scaled = px;
`endif
   always_ff @(posedge vga_clk or posedge reset)
      if (reset) {red, green, blue} <= '0;
      else {red, green, blue} <= blank ? scaled : 12'h000;
endmodule

// File: rtl/scene_sequencer.sv
// scene_sequencer: scene FSM with frame-timed fade-to-black transitions and pixel output.
// Define SCENE_FADE_EN to enable fading; otherwise a transition cuts on the next frame tick.
module scene_sequencer
   import scene_pkg::*;
#(
   parameter int FADE_STEP_FRAMES = 4,
   parameter int INTRO_FRAMES     = 120,
   parameter int GAMEOVER_FRAMES  = 180
) (
   input  logic        vga_clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        blank,
   input  logic        start,
   input  logic        player_dead,
   input  logic        stage_clear,
   input  logic [11:0] title_rgb,
   input  logic [11:0] intro_rgb,
   input  logic [11:0] play_rgb,
   input  logic [11:0] over_rgb,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic [1:0]  scene,
   output logic [3:0]  fade_level,
   output logic        game_active
);
   localparam int HW = $clog2(INTRO_FRAMES > GAMEOVER_FRAMES ? INTRO_FRAMES : GAMEOVER_FRAMES) + 1;
   state_e state_q, state_d;
   scene_e scene_q, scene_d, target_q, target_d;
   logic [HW-1:0] hold_q, hold_d;
   logic start_q, start_edge;
   assign start_edge = start & ~start_q;
`ifdef SCENE_FADE_EN
   localparam int SW = $clog2(FADE_STEP_FRAMES) + 1;
   logic [SW-1:0] step_q, step_d;
   logic [3:0] fade_q, fade_d;
   logic step_wrap;
   assign step_wrap = step_q == SW'(FADE_STEP_FRAMES - 1);
   assign fade_level = fade_q;
`else
   assign fade_level = FADE_MAX;
`endif
   assign scene = scene_q;
   assign game_active = state_q == HOLD_PLAY;
   always_comb begin
      state_d = state_q;
      scene_d = scene_q;
      target_d = target_q;
      hold_d = '0;
`ifdef SCENE_FADE_EN
      fade_d = fade_q;
      step_d = (state_q == FADE_OUT || state_q == FADE_IN) ? step_q : '0;
`endif
      case (state_q)
         HOLD_TITLE: if (start_edge) begin
            state_d = FADE_OUT;
            target_d = SC_INTRO;
         end
         HOLD_INTRO: begin
            hold_d = hold_q + HW'(frame_tick);
            if (frame_tick && hold_q == HW'(INTRO_FRAMES - 1)) begin
               state_d = FADE_OUT;
               target_d = SC_PLAY;
            end
         end
         HOLD_PLAY: if (player_dead || stage_clear) begin
            state_d = FADE_OUT;
            target_d = player_dead ? SC_OVER : SC_INTRO;
         end
         HOLD_OVER: begin
            hold_d = hold_q + HW'(frame_tick);
            if (start_edge || (frame_tick && hold_q == HW'(GAMEOVER_FRAMES - 1))) begin
               state_d = FADE_OUT;
               target_d = SC_TITLE;
            end
         end
`ifdef SCENE_FADE_EN
         FADE_OUT: if (frame_tick) begin
            step_d = step_wrap ? '0 : step_q + SW'(1);
            if (step_wrap) fade_d = fade_q - 4'd1;
            if (step_wrap && fade_q == 4'd1) begin
               scene_d = target_q;
               state_d = FADE_IN;
            end
         end
         FADE_IN: if (frame_tick) begin
            step_d = step_wrap ? '0 : step_q + SW'(1);
            if (step_wrap) fade_d = fade_q + 4'd1;
            if (step_wrap && fade_q == FADE_MAX - 4'd1) state_d = hold_of(scene_q);
         end
`else
         FADE_OUT: if (frame_tick) begin
            scene_d = target_q;
            state_d = hold_of(target_q);
         end
`endif
         default: state_d = HOLD_TITLE;
      endcase
   end
   always_ff @(posedge vga_clk or posedge reset)
      if (reset) begin
         state_q <= HOLD_TITLE;
         scene_q <= SC_TITLE;
         target_q <= SC_TITLE;
         hold_q <= '0;
         start_q <= 1'b1;
      end else begin
         state_q <= state_d;
         scene_q <= scene_d;
         target_q <= target_d;
         hold_q <= hold_d;
         start_q <= start;
      end
`ifdef SCENE_FADE_EN
   always_ff @(posedge vga_clk or posedge reset)
      if (reset) begin
         fade_q <= FADE_MAX;
         step_q <= '0;
      end else begin
         fade_q <= fade_d;
         step_q <= step_d;
      end
`endif
   fade_scaler u_scaler (
      .vga_clk    (vga_clk),
      .reset      (reset),
      .title_rgb  (title_rgb),
      .intro_rgb  (intro_rgb),
      .play_rgb   (play_rgb),
      .over_rgb   (over_rgb),
      .scene      (scene_q),
`ifdef SCENE_FADE_EN
      .fade_level (fade_q),
`endif
      .blank      (blank),
      .red        (red),
      .green      (green),
      .blue       (blue)
   );
endmodule

// File: tb/tb_scene_sequencer.sv
// tb_scene_sequencer: directed scenario tests for scene_sequencer, fade or cut build (SCENE_FADE_EN).
module tb_scene_sequencer;
`ifdef SCENE_FADE_EN
   localparam int T = 32, H = 16;
`else
   localparam int T = 1, H = 1;
`endif
   logic vga_clk = 0, reset = 1, frame_tick = 0, blank = 1, start = 1, player_dead = 0, stage_clear = 0;
   logic [11:0] title_rgb = 12'hFFF, intro_rgb = 12'h123, play_rgb = 12'h456, over_rgb = 12'h9AB;
   logic [3:0] red, green, blue, fade_level;
   logic [1:0] scene;
   logic game_active;
   int errors = 0, checks = 0;
   always #5 vga_clk = ~vga_clk;
   scene_sequencer #(.FADE_STEP_FRAMES(2), .INTRO_FRAMES(4), .GAMEOVER_FRAMES(6)) dut (
      .vga_clk(vga_clk), .reset(reset), .frame_tick(frame_tick), .blank(blank), .start(start),
      .player_dead(player_dead), .stage_clear(stage_clear), .title_rgb(title_rgb), .intro_rgb(intro_rgb),
      .play_rgb(play_rgb), .over_rgb(over_rgb), .red(red), .green(green), .blue(blue), .scene(scene),
      .fade_level(fade_level), .game_active(game_active)
   );
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge vga_clk);
         #1;
      end
   endtask
   task automatic ticks(input int n);
      repeat (n) begin
         frame_tick = 1;
         cyc(1);
         frame_tick = 0;
         cyc(1);
      end
   endtask
   task automatic test_reset;
      cyc(2);
      checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h want 000", {red, green, blue}); end
      reset = 0;
      ticks(10);
      checks++; if (scene !== 2'd0) begin errors++; $display("FAIL reset_scene: got %0d want 0", scene); end
      checks++; if (fade_level !== 4'd8) begin errors++; $display("FAIL reset_fade: got %0d want 8", fade_level); end
      checks++; if (game_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %0b want 0", game_active); end
      start = 0;
      cyc(1);
   endtask
   task automatic test_title_to_intro;
      start = 1;
      cyc(1);
      start = 0;
`ifdef SCENE_FADE_EN
      ticks(2);
      checks++; if (fade_level !== 4'd7) begin errors++; $display("FAIL fade_tick2: got %0d want 7", fade_level); end
      ticks(6);
      checks++; if (fade_level !== 4'd4) begin errors++; $display("FAIL fade_tick8: got %0d want 4", fade_level); end
      checks++; if (red !== 4'h7) begin errors++; $display("FAIL red_fade4: got %h want 7", red); end
      ticks(8);
      checks++; if (fade_level !== 4'd0) begin errors++; $display("FAIL fade_tick16: got %0d want 0", fade_level); end
      checks++; if (scene !== 2'd1) begin errors++; $display("FAIL scene_tick16: got %0d want 1", scene); end
      ticks(16);
`else
      ticks(1);
`endif
      checks++; if (scene !== 2'd1) begin errors++; $display("FAIL intro_scene: got %0d want 1", scene); end
      checks++; if (fade_level !== 4'd8) begin errors++; $display("FAIL intro_fade: got %0d want 8", fade_level); end
      checks++; if (red !== 4'h1) begin errors++; $display("FAIL intro_red: got %h want 1", red); end
   endtask
   task automatic test_intro_to_play;
      ticks(3);
      checks++; if (scene !== 2'd1 || fade_level !== 4'd8) begin errors++; $display("FAIL intro_hold3: got scene %0d fade %0d want 1 8", scene, fade_level); end
      ticks(T);
      checks++; if (game_active !== 1'b0) begin errors++; $display("FAIL active_early: got %0b want 0", game_active); end
      frame_tick = 1;
      cyc(1);
      checks++; if (game_active !== 1'b1) begin errors++; $display("FAIL active_entry: got %0b want 1", game_active); end
      frame_tick = 0;
      cyc(1);
      checks++; if (scene !== 2'd2) begin errors++; $display("FAIL play_scene: got %0d want 2", scene); end
      checks++; if (green !== 4'h5) begin errors++; $display("FAIL play_green: got %h want 5", green); end
   endtask
   task automatic test_stage_clear;
      stage_clear = 1;
      cyc(1);
      stage_clear = 0;
      checks++; if (game_active !== 1'b0) begin errors++; $display("FAIL active_drop: got %0b want 0", game_active); end
      ticks(H - 1);
      checks++; if (scene !== 2'd2) begin errors++; $display("FAIL clear_early: got %0d want 2", scene); end
      ticks(1);
      checks++; if (scene !== 2'd1) begin errors++; $display("FAIL clear_scene: got %0d want 1", scene); end
      ticks(T - H);
      ticks(4 + T);
      checks++; if (scene !== 2'd2 || game_active !== 1'b1) begin errors++; $display("FAIL replay: got scene %0d active %0b want 2 1", scene, game_active); end
   endtask
   task automatic test_dead_priority;
      player_dead = 1;
      stage_clear = 1;
      cyc(1);
      player_dead = 0;
      stage_clear = 0;
      ticks(H);
      checks++; if (scene !== 2'd3) begin errors++; $display("FAIL dead_scene: got %0d want 3", scene); end
      ticks(T - H);
      checks++; if (fade_level !== 4'd8 || game_active !== 1'b0) begin errors++; $display("FAIL over_entry: got fade %0d active %0b want 8 0", fade_level, game_active); end
   endtask
   task automatic test_over_timeout;
      player_dead = 1;
      stage_clear = 1;
      cyc(2);
      player_dead = 0;
      stage_clear = 0;
      ticks(5);
      checks++; if (scene !== 2'd3 || fade_level !== 4'd8) begin errors++; $display("FAIL over_hold5: got scene %0d fade %0d want 3 8", scene, fade_level); end
      ticks(H);
      checks++; if (scene !== 2'd3) begin errors++; $display("FAIL timeout_early: got %0d want 3", scene); end
      ticks(1);
      checks++; if (scene !== 2'd0) begin errors++; $display("FAIL timeout_scene: got %0d want 0", scene); end
      ticks(T - H);
      checks++; if (fade_level !== 4'd8) begin errors++; $display("FAIL title_return_fade: got %0d want 8", fade_level); end
   endtask
   task automatic test_over_start;
      start = 1;
      cyc(1);
      start = 0;
      ticks(T);
      ticks(4 + T);
      player_dead = 1;
      cyc(1);
      player_dead = 0;
      ticks(T);
      checks++; if (scene !== 2'd3) begin errors++; $display("FAIL over_again: got %0d want 3", scene); end
      ticks(2);
      start = 1;
      cyc(1);
      start = 0;
      ticks(H - 1);
      checks++; if (scene !== 2'd3) begin errors++; $display("FAIL start_early: got %0d want 3", scene); end
      ticks(1);
      checks++; if (scene !== 2'd0) begin errors++; $display("FAIL start_scene: got %0d want 0", scene); end
      ticks(T - H);
   endtask
   task automatic test_blank;
      blank = 0;
      cyc(1);
      checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL blank_rgb: got %h want 000", {red, green, blue}); end
      blank = 1;
      title_rgb = 12'hA5C;
      cyc(1);
      checks++; if ({red, green, blue} !== 12'hA5C) begin errors++; $display("FAIL active_rgb: got %h want a5c", {red, green, blue}); end
   endtask
   task automatic test_mid_fade_reset;
      start = 1;
      cyc(1);
      start = 0;
`ifdef SCENE_FADE_EN
      ticks(22);
      checks++; if (fade_level !== 4'd3) begin errors++; $display("FAIL fade_in3: got %0d want 3", fade_level); end
`else
      ticks(1);
`endif
      checks++; if (scene !== 2'd1) begin errors++; $display("FAIL prereset_scene: got %0d want 1", scene); end
      reset = 1;
      #2;
      checks++; if (fade_level !== 4'd8 || scene !== 2'd0) begin errors++; $display("FAIL async_reset: got fade %0d scene %0d want 8 0", fade_level, scene); end
      checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL async_rgb: got %h want 000", {red, green, blue}); end
      cyc(1);
      reset = 0;
      ticks(2);
      checks++; if (scene !== 2'd0 || fade_level !== 4'd8) begin errors++; $display("FAIL post_reset: got scene %0d fade %0d want 0 8", scene, fade_level); end
   endtask
   initial begin
      test_reset;
      test_title_to_intro;
      test_intro_to_play;
      test_stage_clear;
      test_dead_priority;
      test_over_timeout;
      test_over_start;
      test_blank;
      test_mid_fade_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/scene_sequencer.md
# scene_sequencer

Top-level scene controller for the full-screen image mappers (title, stage intro, play field, game over). It selects which mapper's 12-bit pixel reaches the VGA DAC and sequences transitions between scenes. Transitions fade to black and back, timed in frames. It consumes game events and exposes the current scene and a game-active flag to the rest of the game logic.

## Interface
Parameters:
- FADE_STEP_FRAMES, 4: frame ticks per fade-level step (≥1)
- INTRO_FRAMES, 120: frame ticks the intro scene is held at full brightness
- GAMEOVER_FRAMES, 180: frame ticks the game-over scene is held before returning to title

Ports:
- vga_clk  in  1  pixel clock; the only clock
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame, issued during vertical blanking
- blank  in  1  high = active display region
- start  in  1  start key, level
- player_dead  in  1  level, sampled only in PLAY
- stage_clear  in  1  level, sampled only in PLAY
- title_rgb, intro_rgb, play_rgb, over_rgb  in  12 each  {r,g,b} from each mapper
- red, green, blue  out  4 each  pixel to DAC
- scene  out  2  currently displayed scene
- fade_level  out  4  0 (black) … 8 (full)
- game_active  out  1  high only in PLAY

## Operation
- Scene codes: TITLE=0, INTRO=1, PLAY=2, OVER=3.
- FSM states: HOLD_TITLE, HOLD_INTRO, HOLD_PLAY, HOLD_OVER, FADE_OUT, FADE_IN.
- `target` register holds the destination scene during a fade.
- start_edge = start & ~start_q.
  - start_q resets to 1, so a key held through reset produces no edge.
- HOLD_TITLE: start_edge → FADE_OUT, target=INTRO.
- HOLD_INTRO: on the INTRO_FRAMES-th frame_tick → FADE_OUT, target=PLAY.
- HOLD_PLAY: player_dead → FADE_OUT, target=OVER.
  - Otherwise stage_clear → FADE_OUT, target=INTRO.
  - If both are high, player_dead wins.
- HOLD_OVER: on the GAMEOVER_FRAMES-th frame_tick, or on start_edge (whichever comes first) → FADE_OUT, target=TITLE.
- FADE_OUT: step counter counts frame_ticks 0…FADE_STEP_FRAMES−1. At wrap, fade_level decrements.
  - On the tick where fade_level becomes 0: scene ← target, state → FADE_IN.
- FADE_IN: same step counter; fade_level increments at wrap.
  - On reaching 8: state → HOLD_<scene>.
  - Hold counter and step counter clear on entry.
- start, player_dead and stage_clear are ignored during fades and in non-owning hold states.
- Pixel path:
  - Mux the selected input by `scene`.
  - Each channel out = (c × fade_level) >> 3. This is a 4×4 → 8-bit product; take bits [6:3]. fade_level 8 gives identity.
  - Output forced to 0 when blank is low.

## Timing
- Reset values:
  - state HOLD_TITLE, scene TITLE, target TITLE
  - fade_level 8, counters 0, start_q 1
  - red/green/blue 0, game_active 0
- Pixel latency: one vga_clk. Output at cycle n+1 reflects blank, rgb, scene and fade_level sampled at cycle n.
- State, scene, fade_level and counters change only on cycles where frame_tick=1. The exception is the event-triggered exits from HOLD states, which take effect on the cycle after the event is sampled. Fade steps still align to frame_tick.
- Full transition = 16×FADE_STEP_FRAMES frame ticks: 8 steps out, 8 steps in.
- game_active drops the cycle after HOLD_PLAY is left. It rises the cycle the state becomes HOLD_PLAY.
- Reset asserted mid-fade returns immediately to HOLD_TITLE at full brightness.

## Configuration
- SCENE_FADE_EN defined: fading and the multiplier behave as described above.
- Undefined:
  - fade_level is tied to 8 and no multiplier is synthesised.
  - FADE_OUT waits for the next frame_tick, sets scene ← target, and goes directly to HOLD_<target>. FADE_IN is unreachable.
  - All other behaviour is unchanged.

## Structure
- Package scene_pkg: scene code enum, FSM state enum, FADE_MAX=8 constant.
- Sub-module fade_scaler: registered mux + multiply + blank gating. Inputs: four rgb buses, scene, fade_level, blank. Outputs: red/green/blue.
- Top holds the FSM, the step and hold counters, and edge detection.

## Test plan
(FADE_STEP_FRAMES=2, INTRO_FRAMES=4, GAMEOVER_FRAMES=6)
- Reset with start held high, then 10 frame_ticks → state stays HOLD_TITLE, scene=0, fade_level=8, game_active=0.
- Start edge in title, title_rgb=0xFFF → fade_level reads 7 after tick 2 and 0 after tick 16; red=0x7 at fade 4; scene=1 after tick 16; fade_level=8 after tick 32.
- Hold intro for 4 ticks → full transition; game_active=1 exactly when HOLD_PLAY is entered; scene=2.
- In PLAY, assert player_dead and stage_clear in the same cycle → target=OVER; scene=3 after 16 ticks.
- In OVER, no start → after 6 ticks fade to TITLE. Repeat, pulsing start at tick 2 → fade begins early.
- blank=0 with any input → red/green/blue=0 on the next cycle. Reset asserted at fade_level 3 → fade_level=8, scene=0 asynchronously.
